// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch unit and its neighbours: instruction-memory handshake,
// redirect inputs from decode/ALU, and the instruction/status outputs.
interface instr_fetch_unit_if;
   logic        stall;
   logic        pc_sel;
   logic [31:0] alu_data;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] pc_four;
   logic [31:0] instr;
   logic        instr_vld;
   logic        fetch_err;
   logic [31:0] retire_cnt;

   modport master (
      input  stall, pc_sel, alu_data, imem_ack, imem_rdata,
      output imem_req, imem_addr, pc, pc_four, instr, instr_vld, fetch_err, retire_cnt
   );

   modport slave (
      output stall, pc_sel, alu_data, imem_ack, imem_rdata,
      input  imem_req, imem_addr, pc, pc_four, instr, instr_vld, fetch_err, retire_cnt
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ack, presents one word at a time
// with a valid flag, and redirects to the ALU target when decode asks for it.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   instr_fetch_unit_if.master    bus
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_ERR} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q, pc_nxt;
   logic [31:0] instr_q, instr_nxt;
   logic [31:0] cnt_q, cnt_nxt;
   logic        err_q, err_nxt;
   logic [31:0] pc_four;

   assign pc_four = pc_q + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc_q    <= pc_nxt;
         instr_q <= instr_nxt;
         cnt_q   <= cnt_nxt;
         err_q   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      instr_nxt = instr_q;
      cnt_nxt   = cnt_q;
      err_nxt   = err_q;
      case (state)
         S_IDLE: state_nxt = S_REQ;
         S_REQ: begin
            if (bus.imem_ack) begin
               instr_nxt = bus.imem_rdata;
               state_nxt = S_VALID;
            end
         end
         S_VALID: begin
            // Redirect inputs matter only on the consuming edge.
            if (!bus.stall) begin
               cnt_nxt   = cnt_q + 32'd1;
               instr_nxt = NOP_INSTR;
               if (bus.pc_sel && (bus.alu_data[1:0] != 2'b00)) begin
                  err_nxt   = 1'b1;
                  state_nxt = S_ERR;
               end else begin
                  pc_nxt    = bus.pc_sel ? bus.alu_data : pc_four;
                  state_nxt = S_REQ;
               end
            end
         end
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.imem_req   = (state == S_REQ);
   assign bus.imem_addr  = pc_q;
   assign bus.pc         = pc_q;
   assign bus.pc_four    = pc_four;
   assign bus.instr      = instr_q;
   assign bus.instr_vld  = (state == S_VALID);
   assign bus.fetch_err  = err_q;
   assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scenario bench for instr_fetch_unit: fetched words are queued when acked and
// compared against what the unit presents while valid.
module tb_instr_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_pc = '0;
   logic [31:0] exp_cnt = '0;
   exp_t        q[$];

   instr_fetch_unit_if bus();

   instr_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one memory response (ack after 'delay' cycles) and records the expected word.
   task automatic serve(input int delay, input logic [31:0] data);
      repeat (delay) tick();
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = data;
      q.push_back({exp_pc, data});
      tick();
      bus.imem_ack   = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
      checks++; if (bus.instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", bus.instr, NOP); end
      checks++; if (bus.instr_vld !== 1'b0 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_vld_req got=%b%b exp=00", bus.instr_vld, bus.imem_req); end
      checks++; if (bus.fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.fetch_err); end
      checks++; if (bus.retire_cnt !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", bus.retire_cnt); end
      rst = 1'b0;
      exp_pc = '0;
      exp_cnt = '0;
      tick();
   endtask

   task automatic test_stream();
      exp_t e;
      logic ev;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h0000_0033;
      for (int k = 0; k < 6; k++) begin
         ev = (k % 2 == 1);
         checks++; if (bus.instr_vld !== ev) begin failures++; $display("FAIL stream_vld k=%0d got=%b exp=%b", k, bus.instr_vld, ev); end
         if (!ev) begin
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin failures++; $display("FAIL stream_req k=%0d got=%b/%h exp=1/%h", k, bus.imem_req, bus.imem_addr, exp_pc); end
            q.push_back({exp_pc, 32'h0000_0033});
         end else begin
            e = q.pop_front();
            checks++; if (bus.pc !== e.pc || bus.instr !== e.instr) begin failures++; $display("FAIL stream_word k=%0d got=%h/%h exp=%h/%h", k, bus.pc, bus.instr, e.pc, e.instr); end
            exp_pc  += 32'd4;
            exp_cnt += 32'd1;
         end
         tick();
      end
      bus.imem_ack = 1'b0;
      checks++; if (bus.retire_cnt !== 32'd3 || exp_cnt !== 32'd3) begin failures++; $display("FAIL stream_cnt got=%0d exp=3", bus.retire_cnt); end
   endtask

   task automatic test_ack_delay();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc || bus.instr_vld !== 1'b0) begin failures++; $display("FAIL delay_hold i=%0d got=%b/%h/%b exp=1/%h/0", i, bus.imem_req, bus.imem_addr, bus.instr_vld, exp_pc); end
         if (i == 3) begin
            bus.imem_ack = 1'b1;
            bus.imem_rdata = 32'hA0B0_0093;
            q.push_back({exp_pc, 32'hA0B0_0093});
         end
         tick();
      end
      bus.imem_ack = 1'b0;
      checks++; if (bus.instr_vld !== 1'b1 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL delay_vld got=%b/%b exp=1/0", bus.instr_vld, bus.imem_req); end
      e = q.pop_front();
      checks++; if (bus.pc !== e.pc || bus.instr !== e.instr) begin failures++; $display("FAIL delay_word got=%h/%h exp=%h/%h", bus.pc, bus.instr, e.pc, e.instr); end
      tick();
      exp_pc += 32'd4; exp_cnt += 32'd1;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc || bus.retire_cnt !== exp_cnt) begin failures++; $display("FAIL delay_next got=%h/%0d exp=%h/%0d", bus.imem_addr, bus.retire_cnt, exp_pc, exp_cnt); end
   endtask

   task automatic test_stall();
      exp_t e;
      bus.stall = 1'b1;
      serve(0, 32'h0041_0113);
      e = q.pop_front();
      checks++; if (bus.instr_vld !== 1'b1 || bus.pc !== e.pc || bus.instr !== e.instr) begin failures++; $display("FAIL stall_word got=%b/%h/%h exp=1/%h/%h", bus.instr_vld, bus.pc, bus.instr, e.pc, e.instr); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus.instr_vld !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr !== e.instr || bus.pc !== e.pc || bus.retire_cnt !== exp_cnt) begin failures++; $display("FAIL stall_hold i=%0d got=%b/%b/%h/%h/%0d exp=1/0/%h/%h/%0d", i, bus.instr_vld, bus.imem_req, bus.instr, bus.pc, bus.retire_cnt, e.instr, e.pc, exp_cnt); end
      end
      bus.stall = 1'b0;
      tick();
      exp_pc += 32'd4; exp_cnt += 32'd1;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc || bus.retire_cnt !== exp_cnt) begin failures++; $display("FAIL stall_resume got=%h/%0d exp=%h/%0d", bus.imem_addr, bus.retire_cnt, exp_pc, exp_cnt); end
   endtask

   task automatic test_branch();
      exp_t e;
      bus.pc_sel = 1'b1;
      bus.alu_data = 32'h200;
      serve(1, 32'h0100_006F);
      e = q.pop_front();
      checks++; if (bus.pc !== e.pc || bus.instr !== e.instr) begin failures++; $display("FAIL branch_word got=%h/%h exp=%h/%h", bus.pc, bus.instr, e.pc, e.instr); end
      bus.alu_data = 32'h100;
      tick();
      bus.pc_sel = 1'b0;
      exp_pc = 32'h100; exp_cnt += 32'd1;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc || bus.pc_four !== 32'h104) begin failures++; $display("FAIL branch_target got=%h/%h exp=%h/%h", bus.imem_addr, bus.pc_four, exp_pc, 32'h104); end
   endtask

   task automatic test_wrap();
      exp_t e;
      serve(0, 32'h0000_0073);
      e = q.pop_front();
      checks++; if (bus.pc !== e.pc || bus.instr !== e.instr) begin failures++; $display("FAIL wrap_word got=%h/%h exp=%h/%h", bus.pc, bus.instr, e.pc, e.instr); end
      bus.pc_sel = 1'b1;
      bus.alu_data = 32'hFFFF_FFFC;
      tick();
      bus.pc_sel = 1'b0;
      exp_pc = 32'hFFFF_FFFC; exp_cnt += 32'd1;
      checks++; if (bus.imem_addr !== exp_pc || bus.pc_four !== 32'h0) begin failures++; $display("FAIL wrap_four got=%h/%h exp=%h/0", bus.imem_addr, bus.pc_four, exp_pc); end
      serve(0, 32'h0000_1037);
      e = q.pop_front();
      checks++; if (bus.pc !== e.pc || bus.instr !== e.instr) begin failures++; $display("FAIL wrap_top got=%h/%h exp=%h/%h", bus.pc, bus.instr, e.pc, e.instr); end
      tick();
      exp_pc += 32'd4; exp_cnt += 32'd1;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", bus.imem_addr, exp_pc); end
   endtask

   task automatic test_misaligned();
      exp_t e;
      serve(0, 32'h0020_8063);
      e = q.pop_front();
      checks++; if (bus.pc !== e.pc || bus.instr !== e.instr) begin failures++; $display("FAIL mis_word got=%h/%h exp=%h/%h", bus.pc, bus.instr, e.pc, e.instr); end
      bus.pc_sel = 1'b1;
      bus.alu_data = 32'h102;
      tick();
      bus.pc_sel = 1'b0;
      exp_cnt += 32'd1;
      checks++; if (bus.fetch_err !== 1'b1 || bus.instr_vld !== 1'b0 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL mis_err got=%b/%b/%b exp=1/0/0", bus.fetch_err, bus.instr_vld, bus.imem_req); end
      checks++; if (bus.pc !== exp_pc || bus.instr !== NOP || bus.retire_cnt !== exp_cnt) begin failures++; $display("FAIL mis_state got=%h/%h/%0d exp=%h/%h/%0d", bus.pc, bus.instr, bus.retire_cnt, exp_pc, NOP, exp_cnt); end
      bus.imem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (bus.fetch_err !== 1'b1 || bus.instr_vld !== 1'b0 || bus.imem_req !== 1'b0 || bus.pc !== exp_pc || bus.retire_cnt !== exp_cnt) begin failures++; $display("FAIL mis_sticky i=%0d got=%b/%b/%b/%h exp=1/0/0/%h", i, bus.fetch_err, bus.instr_vld, bus.imem_req, bus.pc, exp_pc); end
      end
      bus.imem_ack = 1'b0;
   endtask

   task automatic test_reset_mid_fetch();
      exp_t e;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_pc = '0; exp_cnt = '0;
      q.delete();
      tick();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.fetch_err !== 1'b0) begin failures++; $display("FAIL rst_clear got=%b/%h/%b exp=1/0/0", bus.imem_req, bus.imem_addr, bus.fetch_err); end
      tick();
      rst = 1'b1;
      #1;
      checks++; if (bus.imem_req !== 1'b0 || bus.pc !== 32'h0 || bus.instr_vld !== 1'b0 || bus.retire_cnt !== 32'h0 || bus.instr !== NOP) begin failures++; $display("FAIL rst_async got=%b/%h/%b/%0d/%h exp=0/0/0/0/%h", bus.imem_req, bus.pc, bus.instr_vld, bus.retire_cnt, bus.instr, NOP); end
      tick();
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      rst = 1'b0;
      tick();
      bus.imem_ack = 1'b0;
      checks++; if (bus.imem_req !== 1'b1 || bus.instr_vld !== 1'b0 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rst_lateack got=%b/%b/%h exp=1/0/0", bus.imem_req, bus.instr_vld, bus.imem_addr); end
      tick();
      checks++; if (bus.imem_req !== 1'b1 || bus.instr_vld !== 1'b0 || bus.instr !== NOP) begin failures++; $display("FAIL rst_noaccept got=%b/%b/%h exp=1/0/%h", bus.imem_req, bus.instr_vld, bus.instr, NOP); end
      serve(0, 32'h0000_0033);
      e = q.pop_front();
      checks++; if (bus.instr_vld !== 1'b1 || bus.pc !== e.pc || bus.instr !== e.instr) begin failures++; $display("FAIL rst_restart got=%b/%h/%h exp=1/%h/%h", bus.instr_vld, bus.pc, bus.instr, e.pc, e.instr); end
   endtask

   initial begin
      bus.stall      = 1'b0;
      bus.pc_sel     = 1'b0;
      bus.alu_data   = '0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      test_reset();
      test_stream();
      test_ack_delay();
      test_stall();
      test_branch();
      test_wrap();
      test_misaligned();
      test_reset_mid_fetch();
      checks++; if (q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
